// File: rtl/ppu_mode_sequencer_pkg.sv
// ppu_mode_sequencer_pkg: state encodings, linemult codes and default limits for the PPU mode sequencer.
package ppu_mode_sequencer_pkg;
   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_BLANK     = 3'd1,
      ST_HOLD      = 3'd2,
      ST_WAIT_LOCK = 3'd3,
      ST_SETTLE    = 3'd4
   } seq_state_e;
   localparam logic [1:0] LM_X1 = 2'b00;
   localparam logic [1:0] LM_X2 = 2'b01;
   localparam logic [1:0] LM_X3 = 2'b10;
   localparam int DEF_CFG_W         = 8;
   localparam int DEF_HOLD_CYCLES   = 255;
   localparam int DEF_LOCK_STABLE   = 16;
   localparam int DEF_LOCK_TIMEOUT  = 1048575;
   localparam int DEF_FRAME_TIMEOUT = 2097151;
   localparam int DEF_SETTLE_FRAMES = 2;
   function automatic logic is_x3(input logic [1:0] lm);
      return lm == LM_X3;
   endfunction
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/ppu_mode_sequencer_if.sv
// ppu_mode_sequencer_if: config request/sync inputs and sequenced config/reset/blank outputs.
interface ppu_mode_sequencer_if #(parameter int CFG_W = 8);
   logic [CFG_W-1:0] cfg_req;
   logic [CFG_W-1:0] cfg_active;
   logic             nvsync;
   logic             pll_locked;
   logic             rst_tx;
   logic             blank;
   logic             fallback;
   logic [2:0]       state;
   modport master (output cfg_req, nvsync, pll_locked, input cfg_active, rst_tx, blank, fallback, state);
   modport slave (input cfg_req, nvsync, pll_locked, output cfg_active, rst_tx, blank, fallback, state);
endinterface

// File: rtl/ppu_mode_sequencer_timer.sv
// ppu_mode_sequencer_timer: saturating up-counter with clear and enable; tc marks the LIM-th counted cycle.
module ppu_mode_sequencer_timer #(
   parameter int W   = 8,
   parameter int LIM = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [W-1:0] cnt;
   assign tc = cnt == W'(LIM - 1);
   always_ff @(posedge clk)
      cnt <= (rst || clr) ? '0 : (en && !tc) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/ppu_mode_sequencer.sv
// ppu_mode_sequencer: sequences output config changes (blank on frame edge, hold Tx reset,
// wait for LineX3 PLL lock with LineX2 fallback, settle frames, unblank) in the VCLK domain.
module ppu_mode_sequencer
   import ppu_mode_sequencer_pkg::*;
#(
   parameter int CFG_W         = DEF_CFG_W,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int LOCK_STABLE   = DEF_LOCK_STABLE,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
   parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
   input logic VCLK,
   input logic VRST,
   ppu_mode_sequencer_if.slave bus
);
   localparam int TW = $clog2(max2(max2(max2(HOLD_CYCLES, LOCK_STABLE), max2(LOCK_TIMEOUT, FRAME_TIMEOUT)), SETTLE_FRAMES) + 1);
   seq_state_e st, nxt;
   logic [CFG_W-1:0] cfg_tgt, cfg_act;
   logic nv_q, nv_d, rst_tx, blank, fallback;
   logic vs_fe, frame, req_chg, restart, load, demote, pll_lost, lock_ok;
   logic h_tc, s_tc, t_tc, f_tc, n_tc;
   assign vs_fe    = nv_d & ~nv_q;
   assign frame    = vs_fe | f_tc;
   assign req_chg  = bus.cfg_req != cfg_tgt;
   assign lock_ok  = s_tc & bus.pll_locked;
   assign restart  = req_chg && (st == ST_HOLD || st == ST_WAIT_LOCK || st == ST_SETTLE);
   assign load     = restart || (st == ST_BLANK && frame);
   assign demote   = st == ST_WAIT_LOCK && !req_chg && !lock_ok && t_tc;
   assign pll_lost = st == ST_RUN && !req_chg && is_x3(cfg_act[1:0]) && !bus.pll_locked;
   ppu_mode_sequencer_timer #(.W(TW), .LIM(HOLD_CYCLES)) u_hold (
      .clk(VCLK), .rst(VRST), .clr(st != ST_HOLD || req_chg), .en(1'b1), .tc(h_tc));
   ppu_mode_sequencer_timer #(.W(TW), .LIM(LOCK_STABLE)) u_stable (
      .clk(VCLK), .rst(VRST), .clr(st != ST_WAIT_LOCK || !bus.pll_locked), .en(1'b1), .tc(s_tc));
   ppu_mode_sequencer_timer #(.W(TW), .LIM(LOCK_TIMEOUT)) u_lock (
      .clk(VCLK), .rst(VRST), .clr(st != ST_WAIT_LOCK), .en(1'b1), .tc(t_tc));
   // frame timer restarts on every vsync edge so a missing vsync counts as one frame per timeout
   ppu_mode_sequencer_timer #(.W(TW), .LIM(FRAME_TIMEOUT)) u_frame (
      .clk(VCLK), .rst(VRST), .clr(!(st == ST_BLANK || st == ST_SETTLE) || frame), .en(1'b1), .tc(f_tc));
   ppu_mode_sequencer_timer #(.W(TW), .LIM(SETTLE_FRAMES)) u_settle (
      .clk(VCLK), .rst(VRST), .clr(st != ST_SETTLE), .en(frame), .tc(n_tc));
   always_comb begin
      nxt = st;
      case (st)
         ST_RUN:       nxt = (req_chg || pll_lost) ? ST_BLANK : ST_RUN;
         ST_BLANK:     nxt = frame ? ST_HOLD : ST_BLANK;
         ST_HOLD:      nxt = req_chg ? ST_HOLD : !h_tc ? ST_HOLD : is_x3(cfg_act[1:0]) ? ST_WAIT_LOCK : ST_SETTLE;
         ST_WAIT_LOCK: nxt = req_chg ? ST_HOLD : lock_ok ? ST_SETTLE : t_tc ? ST_HOLD : ST_WAIT_LOCK;
         ST_SETTLE:    nxt = req_chg ? ST_HOLD : (frame && n_tc) ? ST_RUN : ST_SETTLE;
         default:      nxt = ST_BLANK;
      endcase
   end
   always_ff @(posedge VCLK) begin
      if (VRST) begin
         st       <= ST_BLANK;
         cfg_tgt  <= '0;
         cfg_act  <= '0;
         rst_tx   <= 1'b1;
         blank    <= 1'b1;
         fallback <= 1'b0;
         nv_q     <= 1'b0;
         nv_d     <= 1'b0;
      end else begin
         st     <= nxt;
         rst_tx <= nxt == ST_HOLD || nxt == ST_WAIT_LOCK;
         blank  <= nxt != ST_RUN;
         nv_q   <= bus.nvsync;
         nv_d   <= nv_q;
         if (load) begin
            cfg_tgt <= bus.cfg_req;
            cfg_act <= bus.cfg_req;
         end else if (demote)
            cfg_act[1:0] <= LM_X2;
         // cfg_tgt keeps the LineX3 request after demotion so it does not retrigger
         if (pll_lost || demote)
            fallback <= 1'b1;
         else if (restart && !is_x3(bus.cfg_req[1:0]))
            fallback <= 1'b0;
      end
   end
   assign bus.state      = st;
   assign bus.cfg_active = cfg_act;
   assign bus.rst_tx     = rst_tx;
   assign bus.blank      = blank;
   assign bus.fallback   = fallback;
endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// tb_ppu_mode_sequencer: directed scenarios plus random traffic, every cycle checked
// against a cycle-count reference model of the sequencing rules.
module tb_ppu_mode_sequencer;
   localparam int HC = 8, LS = 4, LT = 64, FT = 200, SF = 2;
   logic VCLK = 1'b0;
   logic VRST;
   always #5 VCLK = ~VCLK;
   ppu_mode_sequencer_if #(.CFG_W(8)) bus ();
   ppu_mode_sequencer #(
      .CFG_W(8), .HOLD_CYCLES(HC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT),
      .FRAME_TIMEOUT(FT), .SETTLE_FRAMES(SF)
   ) dut (.VCLK(VCLK), .VRST(VRST), .bus(bus));
   int vectors = 0, miscompares = 0;
   int cyc = 0, vs_period = 100, rst_cnt = 0;
   int hist[8];
   int m_st, m_age, m_run, m_gap, m_frames;
   logic [7:0] m_act, m_tgt;
   bit m_fb, m_rst, m_blank, m_nv1, m_nv2;
   logic [7:0] picks[6] = '{8'h00, 8'h01, 8'h02, 8'h06, 8'h05, 8'h0A};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic model_step();
      bit fe, fr, chg, go;
      int ns;
      if (VRST) begin
         m_st = 1; m_act = 0; m_tgt = 0; m_fb = 0; m_rst = 1; m_blank = 1;
         m_nv1 = 0; m_nv2 = 0; m_age = 0; m_run = 0; m_gap = 0; m_frames = 0;
         return;
      end
      fe = m_nv2 && !m_nv1;
      m_nv2 = m_nv1;
      m_nv1 = bus.nvsync;
      fr = fe || (m_gap + 1 >= FT);
      chg = bus.cfg_req != m_tgt;
      m_run = (m_st == 3 && bus.pll_locked) ? m_run + 1 : 0;
      ns = m_st;
      go = 0;
      if (chg && m_st >= 2) begin
         m_tgt = bus.cfg_req; m_act = bus.cfg_req;
         if (bus.cfg_req[1:0] != 2'b10) m_fb = 0;
         ns = 2; go = 1;
      end else if (m_st == 0) begin
         if (chg) ns = 1;
         else if (m_act[1:0] == 2'b10 && !bus.pll_locked) begin ns = 1; m_fb = 1; end
      end else if (m_st == 1) begin
         if (fr) begin ns = 2; m_tgt = bus.cfg_req; m_act = bus.cfg_req; end
      end else if (m_st == 2) begin
         if (m_age + 1 >= HC) ns = (m_act[1:0] == 2'b10) ? 3 : 4;
      end else if (m_st == 3) begin
         if (m_run >= LS) ns = 4;
         else if (m_age + 1 >= LT) begin m_act[1:0] = 2'b01; m_fb = 1; ns = 2; end
      end else if (fr) begin
         m_frames++;
         if (m_frames >= SF) ns = 0;
      end
      if (ns != m_st || go) begin
         m_age = 0; m_gap = 0; m_frames = 0; m_run = 0;
      end else begin
         m_age++;
         m_gap = fr ? 0 : m_gap + 1;
      end
      m_st = ns;
      m_rst = ns == 2 || ns == 3;
      m_blank = ns != 0;
   endtask
   function automatic logic [31:0] dut_vec();
      return {18'd0, bus.state, bus.cfg_active, bus.rst_tx, bus.blank, bus.fallback};
   endfunction
   task automatic tick();
      @(posedge VCLK);
      model_step();
      @(negedge VCLK);
      hist[bus.state]++;
      if (bus.rst_tx) rst_cnt++;
      chk("model", dut_vec(), {18'd0, 3'(m_st), m_act, m_rst, m_blank, m_fb});
      cyc++;
      bus.nvsync = (vs_period == 0) || ((cyc % vs_period) >= 3);
   endtask
   task automatic clr_hist();
      foreach (hist[i]) hist[i] = 0;
      rst_cnt = 0;
   endtask
   task automatic wait_state(input int s, input int budget, input string tag);
      int n = 0;
      while (bus.state != 3'(s) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.state), 32'(s));
   endtask
   initial begin
      VRST = 1'b1;
      bus.cfg_req = 8'h01;
      bus.nvsync = 1'b1;
      bus.pll_locked = 1'b1;
      tick();
      chk("reset", dut_vec(), {18'd0, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0});
      repeat (2) tick();
      VRST = 1'b0;
      clr_hist();
      wait_state(0, 1000, "s1_run");
      chk("s1_rst_len", rst_cnt, HC);
      chk("s1_cfg", 32'(bus.cfg_active), 32'h01);
      bus.cfg_req = 8'h02;
      clr_hist();
      wait_state(1, 5, "s2_blank");
      wait_state(0, 1000, "s2_run");
      chk("s2_hold", hist[2], HC);
      chk("s2_wait", hist[3], LS);
      chk("s2_cfg", {bus.cfg_active, 7'd0, bus.fallback}, {8'h02, 8'h00});
      bus.pll_locked = 1'b0;
      clr_hist();
      wait_state(1, 5, "s3_blank");
      wait_state(0, 2000, "s3_run");
      chk("s3_wait", hist[3], LT);
      chk("s3_hold", hist[2], 2 * HC);
      chk("s3_cfg", {bus.cfg_active, 7'd0, bus.fallback}, {8'h01, 8'h01});
      clr_hist();
      repeat (500) tick();
      chk("s3_stay", hist[0], 500);
      vs_period = 0;
      repeat (5) tick();
      bus.cfg_req = 8'h01;
      clr_hist();
      wait_state(1, 5, "s4_blank");
      wait_state(0, 2000, "s4_run");
      chk("s4_blank_len", hist[1], FT);
      chk("s4_settle_len", hist[4], SF * FT);
      vs_period = 100;
      bus.cfg_req = 8'h05;
      wait_state(2, 300, "s5_hold");
      repeat (4) tick();
      bus.cfg_req = 8'h00;
      clr_hist();
      wait_state(4, 50, "s5_settle");
      chk("s5_hold_restart", hist[2], HC);
      chk("s5_cfg0", 32'(bus.cfg_active), 32'h00);
      repeat (10) tick();
      bus.cfg_req = 8'h01;
      clr_hist();
      wait_state(2, 5, "s5_rehold");
      wait_state(0, 1000, "s5_run");
      chk("s5_hold_settle", hist[2], HC);
      chk("s5_cfg1", {bus.cfg_active, 7'd0, bus.fallback}, {8'h01, 8'h00});
      bus.cfg_req = 8'h02;
      wait_state(3, 300, "s6_wait");
      repeat (10) tick();
      VRST = 1'b1;
      tick();
      chk("s6_vrst", dut_vec(), {18'd0, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0});
      VRST = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 299) == 0) bus.cfg_req = picks[$urandom_range(0, 5)];
         if ($urandom_range(0, 39) == 0) bus.pll_locked = ~bus.pll_locked;
         if ($urandom_range(0, 799) == 0) vs_period = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(20, 150);
         VRST = $urandom_range(0, 1999) == 0;
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
